issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue_pkg.sv | 19 +
 rtl/issue_queue_if.sv | 49 ++++
 rtl/issue_queue.sv | 105 ++++++++++
 tb/tb_issue_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// Shared definitions for the instruction issue queue: issue modes,
// bus word types and the stored entry layout.
package issue_queue_pkg;

    localparam logic DUAL_ISSUE   = 1'b1;
    localparam logic SINGLE_ISSUE = 1'b0;

    typedef logic [31:0] inst_bus_t;
    typedef logic [31:0] inst_addr_bus_t;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // One queue slot: instruction word plus its PC.
    typedef struct packed {
        inst_bus_t      inst;
        inst_addr_bus_t addr;
    } iq_entry_t;

endpackage

// File: rtl/issue_queue_if.sv
// Fetch-side and decode-side signals of the issue queue. The master is
// the pipeline (fetch + decode), the slave is the queue itself.
interface issue_queue_if
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 8
) ();

    // Control from the pipeline
    logic                    flush_i;
    logic                    stall_i;
    logic                    issue_mode_i;
    logic                    issued_i;

    // Fetch slots
    logic                    fetch_valid1_i;
    logic                    fetch_valid2_i;
    inst_bus_t               fetch_inst1_i;
    inst_bus_t               fetch_inst2_i;
    inst_addr_bus_t          fetch_addr1_i;
    inst_addr_bus_t          fetch_addr2_i;

    // Head and head+1 presented to decode
    inst_bus_t               inst1_o;
    inst_bus_t               inst2_o;
    inst_addr_bus_t          addr1_o;
    inst_addr_bus_t          addr2_o;
    logic                    inst1_valid_o;
    logic                    inst2_valid_o;
    logic                    full_o;
    logic [$clog2(DEPTH):0]  count_o;

    modport master (
        output flush_i, stall_i, issue_mode_i, issued_i,
        output fetch_valid1_i, fetch_valid2_i,
        output fetch_inst1_i, fetch_inst2_i, fetch_addr1_i, fetch_addr2_i,
        input  inst1_o, inst2_o, addr1_o, addr2_o,
        input  inst1_valid_o, inst2_valid_o, full_o, count_o
    );

    modport slave (
        input  flush_i, stall_i, issue_mode_i, issued_i,
        input  fetch_valid1_i, fetch_valid2_i,
        input  fetch_inst1_i, fetch_inst2_i, fetch_addr1_i, fetch_addr2_i,
        output inst1_o, inst2_o, addr1_o, addr2_o,
        output inst1_valid_o, inst2_valid_o, full_o, count_o
    );

endinterface

// File: rtl/issue_queue.sv
// Instruction issue queue between fetch and decode. Circular buffer of
// DEPTH {inst, addr} entries accepting up to two fetched instructions and
// releasing up to two per cycle. Outputs depend only on registered state,
// so a pushed entry becomes visible one cycle later.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    issue_queue_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q,  head_d;
    logic [PW-1:0] tail_q,  tail_d;
    logic [CW-1:0] count_q, count_d;

    iq_entry_t     entries_q [DEPTH];

    logic          full;
    logic          valid1;
    logic          valid2;
    logic [1:0]    push_n;
    logic [1:0]    pop_n;
    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;

    // Occupancy flags, back-pressure and how many entries move this cycle.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        full    = count_q >= CW'(DEPTH - 1);
        valid1  = count_q >= CW'(1);
        valid2  = count_q >= CW'(2);
        head_p1 = head_q + PW'(1);
        tail_p1 = tail_q + PW'(1);

        push_n = 2'd0;
        if (!full && bus.fetch_valid1_i) begin
            push_n = bus.fetch_valid2_i ? 2'd2 : 2'd1;
        end

        pop_n = 2'd0;
        if (!bus.stall_i && !bus.flush_i && bus.issued_i) begin
            if (bus.issue_mode_i == DUAL_ISSUE && valid2) begin
                pop_n = 2'd2;
            end else if (valid1) begin
                pop_n = 2'd1;
            end
        end
    end

    // Next pointer/occupancy values; flush overrides any push or pop.
    always_comb begin
        head_d  = head_q + PW'(pop_n);
        tail_d  = tail_q + PW'(push_n);
        count_d = count_q + CW'(push_n) - CW'(pop_n);
        if (bus.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers, cleared asynchronously by reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry array write port for the one or two accepted fetch slots.
    // NOTE: the array has no reset; entries outside head..tail are never observed.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0 && !bus.flush_i) begin
            entries_q[tail_q] <= '{inst: bus.fetch_inst1_i, addr: bus.fetch_addr1_i};
            if (push_n == 2'd2) begin
                entries_q[tail_p1] <= '{inst: bus.fetch_inst2_i, addr: bus.fetch_addr2_i};
            end
        end
    end

    // Head and head+1 presented to decode, forced to zero when not occupied.
    always_comb begin
        bus.inst1_valid_o = valid1;
        bus.inst2_valid_o = valid2;
        bus.inst1_o       = valid1 ? entries_q[head_q].inst  : ZERO_WORD;
        bus.addr1_o       = valid1 ? entries_q[head_q].addr  : ZERO_WORD;
        bus.inst2_o       = valid2 ? entries_q[head_p1].inst : ZERO_WORD;
        bus.addr2_o       = valid2 ? entries_q[head_p1].addr : ZERO_WORD;
        bus.full_o        = full;
        bus.count_o       = count_q;
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue (DEPTH=8). Each step drives one cycle of
// stimulus and queues the state expected after that edge (occupancy and
// id of the head entry); a monitor pops and compares on the falling edge.
// Entry id k carries inst {0x24, k[7:0], k[15:0]} at PC 0xBFC00000+4*(k-1).
module tb_issue_queue;

    localparam int DEPTH = 8;

    typedef struct {
        string name;
        int    cnt;
        int    head;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t exp_q [$];

    issue_queue_if #(.DEPTH(DEPTH)) bus ();

    issue_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(int k);
        logic [31:0] v;
        v = {8'h24, k[7:0], k[15:0]};
        return v;
    endfunction

    function automatic logic [31:0] addr_of(int k);
        return 32'hBFC0_0000 + 32'((k - 1) * 4);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, ".inst1"},  bus.inst1_o, 32'h0);
        check({tag, ".inst2"},  bus.inst2_o, 32'h0);
        check({tag, ".addr1"},  bus.addr1_o, 32'h0);
        check({tag, ".addr2"},  bus.addr2_o, 32'h0);
        check({tag, ".valid1"}, 32'(bus.inst1_valid_o), 32'h0);
        check({tag, ".valid2"}, 32'(bus.inst2_valid_o), 32'h0);
        check({tag, ".count"},  32'(bus.count_o), 32'h0);
        check({tag, ".full"},   32'(bus.full_o), 32'h0);
    endtask

    // One cycle of stimulus; slot 2 carries id kid+1.
    task automatic step(string name, bit fv1, bit fv2, int kid, bit mode,
                        bit issued, bit stall, bit flush, int exp_cnt, int exp_head);
        exp_t e;
        bus.fetch_valid1_i = fv1;
        bus.fetch_valid2_i = fv2;
        bus.fetch_inst1_i  = inst_of(kid);
        bus.fetch_addr1_i  = addr_of(kid);
        bus.fetch_inst2_i  = inst_of(kid + 1);
        bus.fetch_addr2_i  = addr_of(kid + 1);
        bus.issue_mode_i   = mode;
        bus.issued_i       = issued;
        bus.stall_i        = stall;
        bus.flush_i        = flush;
        @(posedge clk);
        #1;
        e.name = name;
        e.cnt  = exp_cnt;
        e.head = exp_head;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.fetch_valid1_i = 1'b0;
        bus.fetch_valid2_i = 1'b0;
        bus.fetch_inst1_i  = 32'h0;
        bus.fetch_addr1_i  = 32'h0;
        bus.fetch_inst2_i  = 32'h0;
        bus.fetch_addr2_i  = 32'h0;
        bus.issue_mode_i   = 1'b0;
        bus.issued_i       = 1'b0;
        bus.stall_i        = 1'b0;
        bus.flush_i        = 1'b0;
    endtask

    // Monitor: compare the presented outputs against the oldest expectation.
    initial begin
        exp_t        e;
        bit          v1;
        bit          v2;
        logic [31:0] ei1, ea1, ei2, ea2;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                v1  = e.cnt >= 1;
                v2  = e.cnt >= 2;
                ei1 = v1 ? inst_of(e.head)     : 32'h0;
                ea1 = v1 ? addr_of(e.head)     : 32'h0;
                ei2 = v2 ? inst_of(e.head + 1) : 32'h0;
                ea2 = v2 ? addr_of(e.head + 1) : 32'h0;
                check({e.name, ".count"},  32'(bus.count_o), 32'(e.cnt));
                check({e.name, ".full"},   32'(bus.full_o), 32'((DEPTH - e.cnt) < 2));
                check({e.name, ".valid1"}, 32'(bus.inst1_valid_o), 32'(v1));
                check({e.name, ".valid2"}, 32'(bus.inst2_valid_o), 32'(v2));
                check({e.name, ".inst1"},  bus.inst1_o, ei1);
                check({e.name, ".addr1"},  bus.addr1_o, ea1);
                check({e.name, ".inst2"},  bus.inst2_o, ei2);
                check({e.name, ".addr2"},  bus.addr2_o, ea2);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // Stimulus.
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        idle_inputs();
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        //    name             fv1 fv2 kid mode iss stl fl  cnt head
        step("push_1_2",        1,  1,  1,  0,  0,  0,  0,  2,  1);
        step("idle",            0,  0,  0,  0,  0,  0,  0,  2,  1);
        step("push_3_4",        1,  1,  3,  0,  0,  0,  0,  4,  1);
        step("push_5_6",        1,  1,  5,  0,  0,  0,  0,  6,  1);
        step("push_7",          1,  0,  7,  0,  0,  0,  0,  7,  1);
        step("push_full_drop",  1,  0,  8,  0,  0,  0,  0,  7,  1);
        step("stall",           0,  0,  0,  1,  1,  1,  0,  7,  1);
        step("pop1",            0,  0,  0,  0,  1,  0,  0,  6,  2);
        step("pop2_a",          0,  0,  0,  1,  1,  0,  0,  4,  4);
        step("pop2_b",          0,  0,  0,  1,  1,  0,  0,  2,  6);
        step("pop1_b",          0,  0,  0,  0,  1,  0,  0,  1,  7);
        step("slot2_only",      0,  1, 50,  0,  0,  0,  0,  1,  7);
        step("push_8_9_wrap",   1,  1,  8,  0,  0,  0,  0,  3,  7);
        step("pop1_cnt3",       0,  0,  0,  0,  1,  0,  0,  2,  8);
        step("push_10",         1,  0, 10,  0,  0,  0,  0,  3,  8);
        step("pop2_push2",      1,  1, 11,  1,  1,  0,  0,  3, 10);
        step("pop2_c",          0,  0,  0,  1,  1,  0,  0,  1, 12);
        step("push_13_14",      1,  1, 13,  0,  0,  0,  0,  3, 12);
        step("push_15_16",      1,  1, 15,  0,  0,  0,  0,  5, 12);
        step("flush",           1,  1, 17,  1,  1,  0,  1,  0,  0);
        step("pop_empty",       0,  0,  0,  1,  1,  0,  0,  0,  0);
        step("push_19_20",      1,  1, 19,  0,  0,  0,  0,  2, 19);
        step("pop1_c",          0,  0,  0,  0,  1,  0,  0,  1, 20);
        step("push_21_22",      1,  1, 21,  0,  0,  0,  0,  3, 20);
        step("push_23",         1,  0, 23,  0,  0,  0,  0,  4, 20);
        idle_inputs();

        // Let the monitor consume the count=4 expectation, then assert
        // reset between edges and look at the outputs straight away.
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");

        // A push held across an edge while reset is low is discarded.
        bus.fetch_valid1_i = 1'b1;
        bus.fetch_inst1_i  = inst_of(99);
        bus.fetch_addr1_i  = addr_of(99);
        @(posedge clk);
        #1;
        check_all_zero("rst_push");
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;

        step("post_rst_idle",   0,  0,  0,  0,  0,  0,  0,  0,  0);
        step("post_rst_push",   1,  0, 24,  0,  0,  0,  0,  1, 24);
        idle_inputs();

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
